fp32_seq_multiplier: RTL

- Iterative IEEE-754 single-precision multiplier; the multiply counterpart of the team's combinational fp32 divider datapath.
- Accepts two fp32 operands over a valid/ready handshake.
- Forms the 24x24 significand product by shift-add over several cycles.
- Normalises, rounds and packs the result, then presents it on a held output handshake to the arithmetic-unit result mux.

---
 rtl/fp32_pkg.sv | 35 +++
 rtl/fp32_sig_shift_add.sv | 68 ++++++
 rtl/fp32_seq_multiplier.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/fp32_pkg.sv
// Shared fp32 field constants, controller state encoding and operand classifiers
// for the iterative single-precision multiplier.
package fp32_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int SIG_W  = FRAC_W + 1;
  localparam int PROD_W = 2 * SIG_W;
  localparam int BIAS   = 127;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_MUL    = 3'd2,
    S_NORM   = 3'd3,
    S_ROUND  = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  endfunction

  // Exponent field zero covers both true zero and flushed denormals.
  function automatic logic is_zero(input logic [31:0] x);
    return (x[30:23] == 8'h00);
  endfunction

endpackage

// File: rtl/fp32_sig_shift_add.sv
// Iterative 24x24 significand multiplier: BITS_PER_CYCLE multiplier bits are
// folded into a 48-bit accumulator per cycle. done_o is high during the final
// iteration so the controller can leave its wait state on the same edge that
// writes the last partial product.
module fp32_sig_shift_add
  import fp32_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [SIG_W-1:0]  a_i,
  input  logic [SIG_W-1:0]  b_i,
  output logic              done_o,
  output logic [PROD_W-1:0] prod_o
);

  localparam int ITERS = SIG_W / BITS_PER_CYCLE;

  if (!((BITS_PER_CYCLE == 1) || (BITS_PER_CYCLE == 2) ||
        (BITS_PER_CYCLE == 4) || (BITS_PER_CYCLE == 8))) begin : g_bad_bpc
    $error("fp32_sig_shift_add: BITS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  logic [PROD_W-1:0] acc_q, acc_d;
  logic [PROD_W-1:0] mcand_q;
  logic [SIG_W-1:0]  mplier_q;
  logic [4:0]        cnt_q;
  logic              busy_q;
  logic              last;

  assign last   = busy_q && (cnt_q == 5'(ITERS - 1));
  assign done_o = last;
  assign prod_o = acc_q;

  // Sum of this iteration's partial products on top of the running accumulator.
  always_comb begin
    acc_d = acc_q;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (mplier_q[j]) acc_d = acc_d + (mcand_q << j);
    end
  end

  // Load operands on start, then shift multiplicand left / multiplier right each iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start_i) begin
      acc_q    <= '0;
      mcand_q  <= {{(PROD_W - SIG_W){1'b0}}, a_i};
      mplier_q <= b_i;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << BITS_PER_CYCLE;
      mplier_q <= mplier_q >> BITS_PER_CYCLE;
      cnt_q    <= cnt_q + 5'd1;
      if (last) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/fp32_seq_multiplier.sv
// Iterative IEEE-754 single-precision multiplier with valid/ready operand input
// and a held valid/ready result output. Denormal inputs flush to zero.
// Build option FP32_MUL_RNE_EN: when defined, round-to-nearest-even; otherwise
// the fraction is truncated (ROUND state still traversed, latency unchanged).
module fp32_seq_multiplier
  import fp32_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in1_i,
  input  logic [31:0] in2_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] final_o,
  output logic [2:0]  exc_flags_o
);

  state_e                    state_q;
  logic                      in_ready_q, out_valid_q;
  logic [31:0]               final_q;
  logic [2:0]                flags_q;
  logic [31:0]               a_q, b_q;
  logic                      sign_q;
  logic signed [9:0]         exp_q;
  logic [FRAC_W-1:0]         frac_q;
  logic                      guard_q, sticky_q;

  logic                      special;
  logic [31:0]               spec_final;
  logic [2:0]                spec_flags;
  logic signed [9:0]         exp_sum;
  logic                      mul_start, mul_done;
  logic [PROD_W-1:0]         prod;
  logic [23:0]               rnd;
  logic signed [9:0]         exp_r;
  logic [34:0]               packed_res;

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign final_o     = final_q;
  assign exc_flags_o = flags_q;

  // Returns {carry, fraction}; carry set when the increment ripples out of the fraction.
  function automatic logic [23:0] round_frac(input logic [FRAC_W-1:0] frac,
                                             input logic guard, input logic sticky);
`ifdef FP32_MUL_RNE_EN
    logic inc;
    inc = guard & (sticky | frac[0]);
    return {1'b0, frac} + {23'd0, inc};
`else
    logic unused_gs;
    unused_gs = guard | sticky;
    return {1'b0, frac};
`endif
  endfunction

  // Saturates the biased exponent: returns {final[31:0], flags[2:0]}.
  function automatic logic [34:0] pack_result(input logic sign, input logic signed [9:0] e,
                                              input logic [FRAC_W-1:0] frac);
    if (e >= 10'sd255)    return {sign, 8'hFF, 23'd0, 3'b010};
    else if (e <= 10'sd0) return {sign, 31'd0, 3'b001};
    else                  return {sign, e[EXP_W-1:0], frac, 3'b000};
  endfunction

  // Operand classification and exponent sum for the UNPACK decision.
  always_comb begin
    spec_final = '0;
    spec_flags = '0;
    special    = 1'b0;
    if (is_nan(a_q) || is_nan(b_q) ||
        (is_inf(a_q) && is_zero(b_q)) || (is_zero(a_q) && is_inf(b_q))) begin
      special    = 1'b1;
      spec_final = QNAN;
      spec_flags = 3'b100;
    end else if (is_inf(a_q) || is_inf(b_q)) begin
      special    = 1'b1;
      spec_final = {a_q[31] ^ b_q[31], 8'hFF, 23'd0};
    end else if (is_zero(a_q) || is_zero(b_q)) begin
      special    = 1'b1;
      spec_final = {a_q[31] ^ b_q[31], 31'd0};
    end
    exp_sum = $signed({2'b00, a_q[30:23]}) + $signed({2'b00, b_q[30:23]}) - 10'(BIAS);
  end

  assign mul_start = (state_q == S_UNPACK) && !special;

  fp32_sig_shift_add #(
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_sig_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (mul_start),
    .a_i     ({1'b1, a_q[FRAC_W-1:0]}),
    .b_i     ({1'b1, b_q[FRAC_W-1:0]}),
    .done_o  (mul_done),
    .prod_o  (prod)
  );

  // Rounding and exponent adjust evaluated during the ROUND state.
  always_comb begin
    rnd        = round_frac(frac_q, guard_q, sticky_q);
    exp_r      = exp_q + $signed({9'd0, rnd[23]});
    packed_res = pack_result(sign_q, exp_r, rnd[FRAC_W-1:0]);
  end

  // Controller FSM with registered handshake, result and datapath state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      final_q     <= '0;
      flags_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      frac_q      <= '0;
      guard_q     <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid_i && in_ready_q) begin
            a_q        <= in1_i;
            b_q        <= in2_i;
            in_ready_q <= 1'b0;
            state_q    <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          sign_q <= a_q[31] ^ b_q[31];
          if (special) begin
            final_q     <= spec_final;
            flags_q     <= spec_flags;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            exp_q   <= exp_sum;
            state_q <= S_MUL;
          end
        end
        S_MUL: begin
          if (mul_done) state_q <= S_NORM;
        end
        S_NORM: begin
          if (prod[47]) begin
            frac_q   <= prod[46:24];
            guard_q  <= prod[23];
            sticky_q <= |prod[22:0];
            exp_q    <= exp_q + 10'sd1;
          end else begin
            frac_q   <= prod[45:23];
            guard_q  <= prod[22];
            sticky_q <= |prod[21:0];
          end
          state_q <= S_ROUND;
        end
        S_ROUND: begin
          final_q     <= packed_res[34:3];
          flags_q     <= packed_res[2:0];
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
